// File: rtl/cam_px_capture.sv
// Camera byte-stream capture: pairs RGB565 bytes into RGB332 pixels and writes them into a
// SCREEN_X x SCREEN_Y buffer. Define CAM_TEST_PATTERN_EN to replace pixel data with colour bars.
module cam_px_capture #(
    parameter int AW       = 15,
    parameter int SCREEN_X = 160,
    parameter int SCREEN_Y = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [7:0]    mem_px_data,
    output logic          px_wr,
    output logic [7:0]    line_cnt,
    output logic          frame_done,
    output logic          overflow
);
    localparam int CW = $clog2(SCREEN_X + 1);
    localparam int RW = $clog2(SCREEN_Y + 1);

    typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_FS, CAP_HI, CAP_LO, DONE} state_t;

    state_t        state, state_nx;
    logic [7:0]    hi;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          line_px;
    logic          href_d;
    logic [7:0]    pix;
    logic          capturing, px_take, line_end, frame_clr;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = WAIT_VS;
            WAIT_VS: if (vsync) state_nx = WAIT_FS;
            WAIT_FS: if (!vsync) state_nx = CAP_HI;
            CAP_HI:  if (vsync) state_nx = DONE;
                     else if (href) state_nx = CAP_LO;
            CAP_LO:  state_nx = vsync ? DONE : CAP_HI;
            DONE:    state_nx = start ? WAIT_FS : IDLE;
            default: state_nx = IDLE;
        endcase
        if (!start && state != DONE) state_nx = IDLE;
    end

    assign capturing = (state == CAP_HI || state == CAP_LO) && start && !vsync;
    assign px_take   = capturing && state == CAP_LO && href;
    assign line_end  = capturing && href_d && !href;
    assign frame_clr = state == WAIT_FS && state_nx == CAP_HI;

    always_comb begin
        pix = 8'h00;
`ifdef CAM_TEST_PATTERN_EN
        if (col < CW'(SCREEN_X / 4))          pix = 8'hE0;
        else if (col < CW'(SCREEN_X / 2))     pix = 8'h1C;
        else if (col < CW'(3 * SCREEN_X / 4)) pix = 8'h03;
        else                                  pix = 8'hFF;
`else
        pix = {hi[7:5], hi[2:0], px_data[4:3]};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hi          <= 8'h00;
            col         <= '0;
            row         <= '0;
            line_px     <= 1'b0;
            href_d      <= 1'b0;
            mem_px_addr <= '0;
            mem_px_data <= 8'h00;
            px_wr       <= 1'b0;
            line_cnt    <= 8'h00;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state      <= state_nx;
            href_d     <= href;
            px_wr      <= 1'b0;
            frame_done <= (state_nx == DONE);

            if (state == CAP_HI && href) hi <= px_data;

            if (frame_clr) begin
                col         <= '0;
                row         <= '0;
                line_px     <= 1'b0;
                line_cnt    <= 8'h00;
                overflow    <= 1'b0;
                mem_px_addr <= '0;
            end

            // col saturates at SCREEN_X so an over-long line keeps flagging overflow
            if (px_take) begin
                line_px <= 1'b1;
                if (col != CW'(SCREEN_X)) col <= col + 1'b1;
                if (col < CW'(SCREEN_X) && row < RW'(SCREEN_Y)) begin
                    px_wr       <= 1'b1;
                    mem_px_addr <= AW'(row) * AW'(SCREEN_X) + AW'(col);
                    mem_px_data <= pix;
                end else begin
                    overflow <= 1'b1;
                end
            end

            // empty lines count toward line_cnt but never advance the row
            if (line_end) begin
                if (line_cnt != 8'hFF) line_cnt <= line_cnt + 8'h01;
                if (line_px) begin
                    col <= '0;
                    if (row != RW'(SCREEN_Y)) row <= row + 1'b1;
                end
                line_px <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cam_px_capture.sv
// Self-checking bench for cam_px_capture: conversion table, frame sequences, overflow,
// start/reset aborts; expected writes are queued at stimulus time and popped on px_wr.
module tb_cam_px_capture;
    localparam int AW = 15;
    localparam int SX = 160;
    localparam int SY = 120;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, vsync = 1'b0, href = 1'b0;
    logic [7:0]    px_data = 8'h00;
    logic [AW-1:0] mem_px_addr;
    logic [7:0]    mem_px_data;
    logic          px_wr, frame_done, overflow;
    logic [7:0]    line_cnt;

    cam_px_capture #(.AW(AW), .SCREEN_X(SX), .SCREEN_Y(SY)) dut (
        .clk(clk), .rst(rst), .start(start), .vsync(vsync), .href(href), .px_data(px_data),
        .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr),
        .line_cnt(line_cnt), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] hi; logic [7:0] lo; logic [7:0] exp; } vec_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;

    vec_t          vecs [6];
    wr_t           sb [$];
    int            checks = 0, errors = 0, wr_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    int            m_col = 0, m_row = 0, m_lcnt = 0;
    bit            m_had = 0, m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (px_wr === 1'b1) begin
            wr_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr actual addr=%0d data=%h expected no write", mem_px_addr, mem_px_data);
            end else begin
                e = sb.pop_front();
                if (mem_px_addr !== e.addr || mem_px_data !== e.data) begin
                    errors++;
                    $display("FAIL px_write actual addr=%0d data=%h expected addr=%0d data=%h",
                             mem_px_addr, mem_px_data, e.addr, e.data);
                end
            end
            wr_cnt++;
            last_addr = mem_px_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_data(input int c, input logic [7:0] conv);
`ifdef CAM_TEST_PATTERN_EN
        if (c < SX / 4) return 8'hE0;
        if (c < SX / 2) return 8'h1C;
        if (c < 3 * SX / 4) return 8'h03;
        return 8'hFF;
`else
        return (c >= 0) ? conv : conv;
`endif
    endfunction

    task automatic send_px(input vec_t v);
        wr_t e;
        href = 1'b1; px_data = v.hi;
        tick();
        px_data = v.lo;
        if (m_col < SX && m_row < SY) begin
            e.addr = AW'(m_row * SX + m_col);
            e.data = model_data(m_col, v.exp);
            sb.push_back(e);
        end else begin
            m_ovf = 1;
        end
        m_had = 1;
        if (m_col < SX) m_col++;
        tick();
    endtask

    task automatic raw_bytes(input int n);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            px_data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        tick();
    endtask

    task automatic end_line();
        href = 1'b0;
        tick();
        if (m_had) begin m_row++; m_col = 0; end
        m_had = 0;
        if (m_lcnt < 255) m_lcnt++;
        chk("line_cnt", line_cnt, m_lcnt);
    endtask

    task automatic frame_start();
        start = 1'b1; vsync = 1'b1; href = 1'b0;
        tick(); tick();
        vsync = 1'b0;
        tick();
        m_col = 0; m_row = 0; m_lcnt = 0; m_had = 0; m_ovf = 0;
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        tick();
        chk("frame_done_hi", frame_done, 1);
        tick();
        chk("frame_done_lo", frame_done, 0);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic drain();
        tick(); tick();
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int w0;
        vecs[0] = '{8'hF8, 8'h00, 8'hE0};
        vecs[1] = '{8'h07, 8'hE0, 8'h1C};
        vecs[2] = '{8'h00, 8'h1F, 8'h03};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{8'hA5, 8'h5A, 8'hB7};
        vecs[5] = '{8'h12, 8'h34, 8'h0A};

        #12;
        chk("rst_addr", mem_px_addr, 0);
        chk("rst_data", mem_px_data, 0);
        chk("rst_wr", px_wr, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk); rst = 1'b1;
        tick();

        // single pixel line, then a conversion-table line on row 1
        frame_start();
        send_px(vecs[0]);
        end_line();
        tick();
        chk("first_wr_cnt", wr_cnt, 1);
        chk("first_addr", last_addr, 0);
        for (int i = 0; i < 6; i++) send_px(vecs[i]);
        end_line();
        frame_end();
        drain();
        chk("hold_addr", mem_px_addr, SX + 5);
        chk("hold_data", mem_px_data, model_data(5, vecs[5].exp));

        // odd byte at end of line is dropped; next line lands on row 1
        frame_start();
        send_px(vecs[1]);
        href = 1'b1; px_data = 8'h55; tick();
        end_line();
        send_px(vecs[2]);
        end_line();
        drain();
        chk("odd_next_row", last_addr, SX);
        frame_end();

        // over-long lines clip at SCREEN_X and flag overflow
        frame_start();
        w0 = wr_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 170; c++) send_px(vecs[c % 6]);
            end_line();
        end
        frame_end();
        drain();
        chk("long_wr_cnt", wr_cnt - w0, 2 * SX);
        chk("long_overflow", overflow, 1);

        // full frame
        frame_start();
        w0 = wr_cnt;
        for (int r = 0; r < SY; r++) begin
            for (int c = 0; c < SX; c++) send_px(vecs[(r * SX + c) % 6]);
            end_line();
        end
        frame_end();
        drain();
        chk("full_wr_cnt", wr_cnt - w0, SX * SY);
        chk("full_last_addr", last_addr, SX * SY - 1);
        chk("full_line_cnt", line_cnt, SY);

        // start dropped mid-pixel: no write, FSM parks until a new vsync sequence
        frame_start();
        send_px(vecs[0]);
        href = 1'b1; px_data = 8'hF8; tick();
        px_data = 8'h00; start = 1'b0; tick();
        href = 1'b0; tick();
        w0 = wr_cnt;
        start = 1'b1;
        raw_bytes(6);
        drain();
        chk("start_abort_no_wr", wr_cnt - w0, 0);

        // reset mid-pixel clears everything immediately and aborts the pixel
        frame_start();
        send_px(vecs[3]);
        end_line();
        href = 1'b1; px_data = 8'h07; tick();
        px_data = 8'hE0;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_addr", mem_px_addr, 0);
        chk("mid_rst_data", mem_px_data, 0);
        chk("mid_rst_wr", px_wr, 0);
        chk("mid_rst_line_cnt", line_cnt, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_overflow", overflow, 0);
        tick();
        href = 1'b0; rst = 1'b1;
        tick();

        // after reset, bytes without a vsync sequence are ignored
        w0 = wr_cnt;
        raw_bytes(6);
        drain();
        chk("post_rst_no_wr", wr_cnt - w0, 0);
        frame_start();
        send_px(vecs[4]);
        end_line();
        drain();
        chk("post_rst_wr_cnt", wr_cnt - w0, 1);
        chk("post_rst_addr", last_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
